// File: rtl/uart_pkg.sv
// Shared UART rate definitions: rate indices, oversample encodings and the
// elaboration-time increment table used by the baud tick generator.
`timescale 1ns/1ps
package uart_pkg;

  localparam logic [2:0] BAUD_2400   = 3'd0;
  localparam logic [2:0] BAUD_4800   = 3'd1;
  localparam logic [2:0] BAUD_9600   = 3'd2;
  localparam logic [2:0] BAUD_19200  = 3'd3;
  localparam logic [2:0] BAUD_38400  = 3'd4;
  localparam logic [2:0] BAUD_57600  = 3'd5;
  localparam logic [2:0] BAUD_115200 = 3'd6;
  localparam logic [2:0] BAUD_CUSTOM = 3'd7;

  localparam logic OS_8  = 1'b0;
  localparam logic OS_16 = 1'b1;

  // Nominal bit rate for a table index; the custom slot has no table rate.
  function automatic longint baud_rate(input int idx);
    case (idx)
      0:       return 64'd2400;
      1:       return 64'd4800;
      2:       return 64'd9600;
      3:       return 64'd19200;
      4:       return 64'd38400;
      5:       return 64'd57600;
      6:       return 64'd115200;
      default: return 64'd0;
    endcase
  endfunction

  // Rounded accumulator increment: round(rate * os * 2^acc_w / clk_hz).
  function automatic longint baud_inc(input int idx, input int os,
                                      input longint clk_hz, input int acc_w);
    longint num;
    num = baud_rate(idx) * longint'(os) * (longint'(1) << acc_w);
    return (num + clk_hz / 2) / clk_hz;
  endfunction

  // Every table entry must be nonzero and fit in the accumulator.
  function automatic bit table_ok(input longint clk_hz, input int acc_w);
    longint inc8;
    longint inc16;
    bit ok;
    ok = 1'b1;
    for (int i = 0; i < 7; i++) begin
      inc8  = baud_inc(i, 8, clk_hz, acc_w);
      inc16 = baud_inc(i, 16, clk_hz, acc_w);
      if (inc8 == 0 || inc8 >= (longint'(1) << acc_w)) ok = 1'b0;
      if (inc16 == 0 || inc16 >= (longint'(1) << acc_w)) ok = 1'b0;
    end
    return ok;
  endfunction

endpackage

// File: rtl/baud_tick_gen.sv
// Fractional baud/oversample tick generator. A phase accumulator overflows at
// rate x oversample; each overflow produces a registered one-cycle SampleTick,
// advances the oversample index and may flag the mid-bit or final slot.
// Strobe semantics: SampleTick, MidTick and BitTick are single-cycle pulses
// with no handshake; a consumer must act in the cycle the strobe is high.
`timescale 1ns/1ps
module baud_tick_gen
  import uart_pkg::*;
#(
  parameter int CLK_FREQ_HZ = 50000000,
  parameter int ACC_W       = 24
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic             Enable,
  input  logic             Resync,
  input  logic [2:0]       BaudSel,
  input  logic             OverSel,
  input  logic [ACC_W-1:0] CustomInc,
  output logic             SampleTick,
  output logic             MidTick,
  output logic             BitTick,
  output logic [3:0]       SubPhase
);

  logic [ACC_W-1:0] inc8Tbl  [8];
  logic [ACC_W-1:0] inc16Tbl [8];

  logic [ACC_W-1:0] acc;
  logic [3:0]       subCount;
  logic [2:0]       shBaudSel;
  logic             shOverSel;
  logic [ACC_W-1:0] shCustomInc;

  logic [ACC_W-1:0] liveInc;
  logic [ACC_W-1:0] runInc;
  logic [ACC_W:0]   sum;
  logic             carry;
  logic [3:0]       osLast;
  logic [3:0]       osMid;

  // Constant increment tables, folded at elaboration.
  for (genvar g = 0; g < 8; g++) begin : g_tbl
    assign inc8Tbl[g]  = ACC_W'(baud_inc(g, 8, CLK_FREQ_HZ, ACC_W));
    assign inc16Tbl[g] = ACC_W'(baud_inc(g, 16, CLK_FREQ_HZ, ACC_W));
  end

  if (!table_ok(CLK_FREQ_HZ, ACC_W)) begin : g_bad_table
    $error("baud_tick_gen: increment table entry is zero or overflows ACC_W");
  end

  // Increment selected by the live inputs; used when loading on Resync.
  always_comb begin
    liveInc = OverSel ? inc16Tbl[BaudSel] : inc8Tbl[BaudSel];
    if (BaudSel == BAUD_CUSTOM) liveInc = CustomInc;
  end

  // Increment selected by the shadow configuration; used while running.
  always_comb begin
    runInc = shOverSel ? inc16Tbl[shBaudSel] : inc8Tbl[shBaudSel];
    if (shBaudSel == BAUD_CUSTOM) runInc = shCustomInc;
  end

  assign sum    = {1'b0, acc} + {1'b0, runInc};
  assign carry  = sum[ACC_W];
  assign osLast = (shOverSel == OS_16) ? 4'd15 : 4'd7;
  assign osMid  = (shOverSel == OS_16) ? 4'd7  : 4'd3;

  // Shadow configuration: only follows the inputs while idle or on Resync.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      shBaudSel   <= BAUD_2400;
      shOverSel   <= OS_8;
      shCustomInc <= '0;
    end else if (!Enable || Resync) begin
      shBaudSel   <= BaudSel;
      shOverSel   <= OverSel;
      shCustomInc <= CustomInc;
    end
  end

  // Accumulator, oversample counter and registered strobes.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      acc        <= '0;
      subCount   <= '0;
      SampleTick <= 1'b0;
      MidTick    <= 1'b0;
      BitTick    <= 1'b0;
    end else if (!Enable) begin
      acc        <= '0;
      subCount   <= '0;
      SampleTick <= 1'b0;
      MidTick    <= 1'b0;
      BitTick    <= 1'b0;
    end else if (Resync) begin
      // Half-increment pre-load centres the first sample in its slot.
      acc        <= liveInc >> 1;
      subCount   <= '0;
      SampleTick <= 1'b0;
      MidTick    <= 1'b0;
      BitTick    <= 1'b0;
    end else begin
      acc        <= sum[ACC_W-1:0];
      SampleTick <= carry;
      MidTick    <= carry && (subCount == osMid);
      BitTick    <= carry && (subCount == osLast);
      if (carry) begin
        subCount <= (subCount == osLast) ? 4'd0 : subCount + 4'd1;
      end
    end
  end

  assign SubPhase = subCount;

endmodule

// File: tb/tb_baud_tick_gen.sv
// Bench for baud_tick_gen: expected strobe events (cycle, flags, SubPhase)
// are derived from the accumulator arithmetic and queued by the driver; a
// negedge monitor pops and compares each strobe the DUT presents.
`timescale 1ns/1ps
module tb_baud_tick_gen;

  localparam int     ACC_W        = 24;
  localparam int     EW           = 39;
  localparam longint TWO_W        = 64'd16777216;
  localparam longint INC_115K_16  = 64'd618475;
  localparam longint INC_9600_16  = 64'd51540;
  localparam longint INC_9600_8   = 64'd25770;
  localparam longint INC_2400_8   = 64'd6442;
  localparam longint INC_HALF     = 64'd8388608;

  logic             Clock;
  logic             Reset;
  logic             Enable;
  logic             Resync;
  logic [2:0]       BaudSel;
  logic             OverSel;
  logic [ACC_W-1:0] CustomInc;
  logic             SampleTick;
  logic             MidTick;
  logic             BitTick;
  logic [3:0]       SubPhase;

  logic [EW-1:0] exp_q[$];
  logic [EW-1:0] exp_v;
  logic [EW-1:0] act_v;
  longint        cyc = 0;
  int            checks = 0;
  int            errors = 0;

  baud_tick_gen #(.CLK_FREQ_HZ(50000000), .ACC_W(ACC_W)) dut (
    .Clock      (Clock),
    .Reset      (Reset),
    .Enable     (Enable),
    .Resync     (Resync),
    .BaudSel    (BaudSel),
    .OverSel    (OverSel),
    .CustomInc  (CustomInc),
    .SampleTick (SampleTick),
    .MidTick    (MidTick),
    .BitTick    (BitTick),
    .SubPhase   (SubPhase)
  );

  // Clock and cycle counter
  initial Clock = 1'b0;
  always #5 Clock = ~Clock;
  always @(posedge Clock) cyc <= cyc + 1;

  // Driver tasks
  task automatic step(input int n);
    repeat (n) @(posedge Clock);
    #1;
  endtask

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic chk_outputs_zero(input string name);
    chk(name, longint'({SampleTick, MidTick, BitTick, SubPhase}), 0);
  endtask

  task automatic chk_empty(input string name);
    chk(name, longint'(exp_q.size()), 0);
    exp_q.delete();
  endtask

  // Tick n lands on add k_n = ceil((n*2^W - a0)/inc) after the start edge
  // (base = cycle of the last edge before the first add). Oversample slot of
  // tick n is (n-1) mod os; SubPhase afterwards is n mod os.
  task automatic push_ticks(input longint base, input longint a0, input longint inc,
                            input int os, input longint limit);
    longint k;
    logic   m;
    logic   b;
    for (int n = 1; n < 100000; n++) begin
      k = (longint'(n) * TWO_W - a0 + inc - 1) / inc;
      if (base + k > limit) break;
      m = ((n - 1) % os) == (os / 2 - 1);
      b = ((n - 1) % os) == (os - 1);
      exp_q.push_back({32'(base + k), 1'b1, m, b, 4'(n % os)});
    end
  endtask

  // Scoreboard monitor
  always @(negedge Clock) begin
    while (exp_q.size() > 0 && exp_q[0][EW-1:7] < cyc[31:0]) begin
      checks++;
      errors++;
      $display("FAIL missed_tick: no strobe at cycle %0d, now %0d", exp_q[0][EW-1:7], cyc);
      void'(exp_q.pop_front());
    end
    if (SampleTick === 1'b1 || MidTick === 1'b1 || BitTick === 1'b1) begin
      checks++;
      act_v = {cyc[31:0], SampleTick, MidTick, BitTick, SubPhase};
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_strobe: cycle %0d s/m/b=%b%b%b sub=%0d, none expected",
                 cyc, SampleTick, MidTick, BitTick, SubPhase);
      end else begin
        exp_v = exp_q.pop_front();
        if (act_v !== exp_v) begin
          errors++;
          $display("FAIL tick_event: got cyc=%0d smb=%b sub=%0d expected cyc=%0d smb=%b sub=%0d",
                   act_v[EW-1:7], act_v[6:4], act_v[3:0], exp_v[EW-1:7], exp_v[6:4], exp_v[3:0]);
        end
      end
    end
  end

  // Directed sequence
  initial begin
    longint e;
    longint r;
    Reset = 1'b1; Enable = 1'b1; Resync = 1'b0;
    BaudSel = 3'd0; OverSel = 1'b0; CustomInc = '0;

    // Reset held with Enable high
    for (int i = 0; i < 3; i++) begin
      step(1);
      chk_outputs_zero("reset_outputs");
    end
    Reset = 1'b0; Enable = 1'b0;
    step(50);
    chk_outputs_zero("idle_outputs");

    // 115200 at 16x from enable; BaudSel change without Resync is ignored
    BaudSel = 3'd6; OverSel = 1'b1;
    step(2);
    e = cyc;
    Enable = 1'b1;
    push_ticks(e, 0, INC_115K_16, 16, e + 1200);
    step(600);
    BaudSel = 3'd2;
    step(600);
    // Resync loads 9600 at 16x and pre-loads half an increment
    Resync = 1'b1;
    r = cyc + 1;
    push_ticks(r, INC_9600_16 / 2, INC_9600_16, 16, r + 6000);
    step(1);
    Resync = 1'b0;
    step(6000);
    Enable = 1'b0;
    step(2);
    chk_empty("resync_run_complete");
    chk_outputs_zero("idle_after_resync_run");

    // 9600 at 8x
    BaudSel = 3'd2; OverSel = 1'b0;
    step(2);
    e = cyc;
    Enable = 1'b1;
    push_ticks(e, 0, INC_9600_8, 8, e + 20000);
    step(20000);
    Enable = 1'b0;
    step(2);
    chk_empty("run_9600_8x_complete");

    // Resync while idle only loads config
    Resync = 1'b1; BaudSel = 3'd6;
    step(1);
    Resync = 1'b0;
    step(20);
    chk_outputs_zero("idle_resync");

    // Custom increment of zero never strobes
    BaudSel = 3'd7; CustomInc = '0;
    step(2);
    Enable = 1'b1;
    step(10000);
    chk("inc0_subphase", longint'(SubPhase), 0);
    chk_empty("inc0_no_ticks");

    // Custom increment 2^23: a tick every 2nd cycle
    Enable = 1'b0; CustomInc = 24'h800000;
    step(2);
    e = cyc;
    Enable = 1'b1;
    push_ticks(e, 0, INC_HALF, 8, e + 40);
    step(40);

    // Reset mid-run; shadow returns to 2400 at 8x while Enable stays high
    Reset = 1'b1;
    step(1);
    chk_outputs_zero("midrun_reset_outputs");
    chk_empty("custom_half_complete");
    Reset = 1'b0;
    e = cyc;
    push_ticks(e, 0, INC_2400_8, 8, e + 12000);
    step(12000);
    Enable = 1'b0;
    step(3);
    chk_empty("post_reset_2400_8x");
    chk_outputs_zero("final_idle");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
